// File: rtl/rv_pipe_pkg.sv
// Shared RISC-V pipeline constants: NOP/halt encodings, major opcodes, PC increment,
// and the fetch halt-FSM state type.
package rv_pipe_pkg;

  localparam logic [31:0] RV_NOP       = 32'h0000_0013;
  localparam logic [31:0] RV_HALT_INSN = 32'h0000_0063;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam int PC_INC = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  function automatic logic [6:0] opcode_of(input logic [31:0] insn);
    return insn[6:0];
  endfunction

  // BEQ x0,x0,0 is a branch to itself; treated as the program's end marker.
  function automatic logic is_halt_insn(input logic [31:0] insn);
    return (opcode_of(insn) == OP_BRANCH) && (insn == RV_HALT_INSN);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble (NOP, invalid), hold keeps contents.
// Priority: reset > flush > hold > load.
module if_id_reg
  import rv_pipe_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_hold,
  input  logic            i_flush,
  input  logic [31:0]     i_instr,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_valid,
  output logic [31:0]     o_instr,
  output logic [PC_W-1:0] o_pc
);

  logic            r_valid;
  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= RV_NOP;
      r_pc    <= '0;
    end else if (i_flush) begin
      // pc of a bubble is meaningless downstream, so it is left as is
      r_valid <= 1'b0;
      r_instr <= RV_NOP;
    end else if (!i_hold) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address, IF/ID capture.
// Optional halt-on-self-loop detection is built when IF_HALT_DETECT_EN is defined.
//
// state   | meaning
// ST_RUN  | fetching normally
// ST_HALT | self-loop word seen; PC frozen, IF/ID fed bubbles until a redirect
module if_fetch_stage
  import rv_pipe_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter int              IMEM_AW  = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [IMEM_AW-1:0] i_mem_addr,
  input  logic [31:0]        i_mem_data,
  output logic [PC_W-1:0]    pc_q,
  output logic               ifid_valid,
  output logic [31:0]        ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               halted
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_redirect_tgt;
  logic            w_halted;
  logic            w_halt_enter;
  logic            w_ifid_flush;
  logic            w_ifid_hold;
  logic            w_unused_tgt_lsbs;

  assign w_redirect_tgt    = {redirect_pc[PC_W-1:2], 2'b00};
  assign w_unused_tgt_lsbs = ^redirect_pc[1:0];

`ifdef IF_HALT_DETECT_EN
  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      w_state_nxt = ST_RUN;
    end else begin
      unique case (r_state)
        ST_RUN:  if (!stall && is_halt_insn(i_mem_data)) w_state_nxt = ST_HALT;
        ST_HALT: w_state_nxt = ST_HALT;
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_comb begin
    w_halted     = (r_state == ST_HALT);
    w_halt_enter = (r_state == ST_RUN) && !redirect && !stall && is_halt_insn(i_mem_data);
  end
`else
  assign w_halted     = 1'b0;
  assign w_halt_enter = 1'b0;
`endif

  // The halt word branches to itself, so the PC already sits on its target when it is captured.
  always_comb begin
    w_pc_nxt = r_pc + PC_W'(PC_INC);
    if (redirect)                              w_pc_nxt = w_redirect_tgt;
    else if (w_halted || stall || w_halt_enter) w_pc_nxt = r_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_pc <= RESET_PC;
    else        r_pc <= w_pc_nxt;
  end

  assign w_ifid_flush = redirect || (w_halted && !stall);
  assign w_ifid_hold  = stall;

  if_id_reg #(
    .PC_W (PC_W)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_hold  (w_ifid_hold),
    .i_flush (w_ifid_flush),
    .i_instr (i_mem_data),
    .i_pc    (r_pc),
    .o_valid (ifid_valid),
    .o_instr (ifid_instr),
    .o_pc    (ifid_pc)
  );

  assign i_mem_addr = r_pc[IMEM_AW-1:0];
  assign pc_q       = r_pc;
  assign halted     = w_halted;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage: a 64-bit PC instance for the main
// scenarios plus an 8-bit PC instance for the wrap-around case.
module tb_if_fetch_stage;
  import rv_pipe_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [5:0]  i_mem_addr;
  logic [31:0] i_mem_data;
  logic [63:0] pc_q;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;
  logic        halted;

  logic        redirect8;
  logic [7:0]  redirect_pc8;
  logic [5:0]  i_mem_addr8;
  logic [31:0] i_mem_data8;
  logic [7:0]  pc_q8;
  logic        ifid_valid8;
  logic [31:0] ifid_instr8;
  logic [7:0]  ifid_pc8;
  logic        halted8;

  logic [31:0] mem [16];

  int checks;
  int fails;

  if_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .i_mem_addr  (i_mem_addr),
    .i_mem_data  (i_mem_data),
    .pc_q        (pc_q),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .halted      (halted)
  );

  if_fetch_stage #(.PC_W(8), .IMEM_AW(6), .RESET_PC(8'h00)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (1'b0),
    .redirect    (redirect8),
    .redirect_pc (redirect_pc8),
    .i_mem_addr  (i_mem_addr8),
    .i_mem_data  (i_mem_data8),
    .pc_q        (pc_q8),
    .ifid_valid  (ifid_valid8),
    .ifid_instr  (ifid_instr8),
    .ifid_pc     (ifid_pc8),
    .halted      (halted8)
  );

  assign i_mem_data  = mem[i_mem_addr[5:2]];
  assign i_mem_data8 = {26'h2AB_0000, i_mem_addr8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [63:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    step();
    redirect    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    redirect8 = 1'b0; redirect_pc8 = '0;
    step(); step();
    checks++; if (pc_q !== 64'd0) begin fails++; $display("FAIL reset_pc got %h exp 0", pc_q); end
    checks++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h0000_0013) begin fails++; $display("FAIL reset_instr got %h exp 00000013", ifid_instr); end
    checks++; if (ifid_pc !== 64'd0) begin fails++; $display("FAIL reset_ifid_pc got %h exp 0", ifid_pc); end
    checks++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b exp 0", halted); end
    // reset held while stall and redirect are both requested
    stall = 1'b1; redirect = 1'b1; redirect_pc = 64'd40;
    step();
    checks++; if (pc_q !== 64'd0) begin fails++; $display("FAIL reset_prio_pc got %h exp 0", pc_q); end
    checks++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL reset_prio_valid got %b exp 0", ifid_valid); end
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rst_n = 1'b1;
    checks++; if (i_mem_addr !== 6'd0) begin fails++; $display("FAIL addr_after_reset got %0d exp 0", i_mem_addr); end
  endtask

  task automatic test_normal();
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_0000 || ifid_pc !== 64'd0)
      begin fails++; $display("FAIL normal_e1 got v=%b %h pc=%0d exp v=1 10000000 pc=0", ifid_valid, ifid_instr, ifid_pc); end
    checks++; if (i_mem_addr !== 6'd4) begin fails++; $display("FAIL normal_addr1 got %0d exp 4", i_mem_addr); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_0001 || ifid_pc !== 64'd4)
      begin fails++; $display("FAIL normal_e2 got v=%b %h pc=%0d exp v=1 10000001 pc=4", ifid_valid, ifid_instr, ifid_pc); end
    checks++; if (i_mem_addr !== 6'd8) begin fails++; $display("FAIL normal_addr2 got %0d exp 8", i_mem_addr); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_0002 || ifid_pc !== 64'd8)
      begin fails++; $display("FAIL normal_e3 got v=%b %h pc=%0d exp v=1 10000002 pc=8", ifid_valid, ifid_instr, ifid_pc); end
    checks++; if (i_mem_addr !== 6'd12) begin fails++; $display("FAIL normal_addr3 got %0d exp 12", i_mem_addr); end
  endtask

  task automatic test_stall();
    do_redirect(64'd4);
    step();
    checks++; if (pc_q !== 64'd8 || ifid_instr !== 32'h1000_0001 || ifid_pc !== 64'd4)
      begin fails++; $display("FAIL stall_setup got pc=%0d %h ipc=%0d exp pc=8 10000001 ipc=4", pc_q, ifid_instr, ifid_pc); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (pc_q !== 64'd8 || ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_0001 || ifid_pc !== 64'd4)
        begin fails++; $display("FAIL stall_hold%0d got pc=%0d v=%b %h ipc=%0d exp pc=8 v=1 10000001 ipc=4",
                                i, pc_q, ifid_valid, ifid_instr, ifid_pc); end
    end
    stall = 1'b0;
    step();
    checks++; if (pc_q !== 64'd12 || ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_0002 || ifid_pc !== 64'd8)
      begin fails++; $display("FAIL stall_release got pc=%0d v=%b %h ipc=%0d exp pc=12 v=1 10000002 ipc=8",
                              pc_q, ifid_valid, ifid_instr, ifid_pc); end
  endtask

  task automatic test_redirect();
    do_redirect(64'd20);
    checks++; if (pc_q !== 64'd20) begin fails++; $display("FAIL redir_setup got %0d exp 20", pc_q); end
    do_redirect(64'd16);
    checks++; if (pc_q !== 64'd16 || ifid_valid !== 1'b0 || ifid_instr !== RV_NOP)
      begin fails++; $display("FAIL redir_flush got pc=%0d v=%b %h exp pc=16 v=0 00000013", pc_q, ifid_valid, ifid_instr); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_0004 || ifid_pc !== 64'd16 || pc_q !== 64'd20)
      begin fails++; $display("FAIL redir_refill got v=%b %h ipc=%0d pc=%0d exp v=1 10000004 ipc=16 pc=20",
                              ifid_valid, ifid_instr, ifid_pc, pc_q); end
    // redirect to the PC already being fetched still costs one bubble
    do_redirect(64'd20);
    checks++; if (pc_q !== 64'd20 || ifid_valid !== 1'b0)
      begin fails++; $display("FAIL redir_same got pc=%0d v=%b exp pc=20 v=0", pc_q, ifid_valid); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_0005 || ifid_pc !== 64'd20)
      begin fails++; $display("FAIL redir_same_refill got v=%b %h ipc=%0d exp v=1 10000005 ipc=20",
                              ifid_valid, ifid_instr, ifid_pc); end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1;
    do_redirect(64'h2E);
    checks++; if (pc_q !== 64'h2C || ifid_valid !== 1'b0 || ifid_instr !== RV_NOP)
      begin fails++; $display("FAIL redir_stall got pc=%h v=%b %h exp pc=2c v=0 00000013", pc_q, ifid_valid, ifid_instr); end
    stall = 1'b0;
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_000B || ifid_pc !== 64'h2C)
      begin fails++; $display("FAIL redir_stall_refill got v=%b %h ipc=%h exp v=1 1000000b ipc=2c",
                              ifid_valid, ifid_instr, ifid_pc); end
  endtask

  task automatic test_alias_wrap();
    do_redirect(64'd64);
    checks++; if (pc_q !== 64'd64 || i_mem_addr !== 6'd0)
      begin fails++; $display("FAIL alias got pc=%0d addr=%0d exp pc=64 addr=0", pc_q, i_mem_addr); end
    step();
    checks++; if (ifid_instr !== 32'h1000_0000 || ifid_pc !== 64'd64)
      begin fails++; $display("FAIL alias_capture got %h ipc=%0d exp 10000000 ipc=64", ifid_instr, ifid_pc); end
    redirect8 = 1'b1; redirect_pc8 = 8'd252;
    step();
    redirect8 = 1'b0;
    checks++; if (pc_q8 !== 8'd252 || i_mem_addr8 !== 6'd60)
      begin fails++; $display("FAIL wrap_setup got pc=%0d addr=%0d exp pc=252 addr=60", pc_q8, i_mem_addr8); end
    step();
    checks++; if (pc_q8 !== 8'd0 || i_mem_addr8 !== 6'd0 || ifid_pc8 !== 8'd252 || ifid_instr8 !== 32'hAAC0_003C)
      begin fails++; $display("FAIL wrap got pc=%0d addr=%0d ipc=%0d %h exp pc=0 addr=0 ipc=252 aac0003c",
                              pc_q8, i_mem_addr8, ifid_pc8, ifid_instr8); end
    checks++; if (halted8 !== 1'b0 || ifid_valid8 !== 1'b1)
      begin fails++; $display("FAIL wrap_flags got halted=%b v=%b exp halted=0 v=1", halted8, ifid_valid8); end
  endtask

  task automatic test_halt();
    do_redirect(64'd56);
    step();
    checks++; if (pc_q !== 64'd60 || ifid_instr !== 32'h1000_000E)
      begin fails++; $display("FAIL halt_setup got pc=%0d %h exp pc=60 1000000e", pc_q, ifid_instr); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== RV_HALT_INSN || ifid_pc !== 64'd60)
      begin fails++; $display("FAIL halt_capture got v=%b %h ipc=%0d exp v=1 00000063 ipc=60", ifid_valid, ifid_instr, ifid_pc); end
`ifdef IF_HALT_DETECT_EN
    checks++; if (halted !== 1'b1 || pc_q !== 64'd60)
      begin fails++; $display("FAIL halt_enter got halted=%b pc=%0d exp halted=1 pc=60", halted, pc_q); end
    step();
    checks++; if (halted !== 1'b1 || pc_q !== 64'd60 || ifid_valid !== 1'b0 || ifid_instr !== RV_NOP)
      begin fails++; $display("FAIL halt_hold got halted=%b pc=%0d v=%b %h exp 1 60 0 00000013",
                              halted, pc_q, ifid_valid, ifid_instr); end
    stall = 1'b1;
    step();
    stall = 1'b0;
    checks++; if (halted !== 1'b1 || pc_q !== 64'd60)
      begin fails++; $display("FAIL halt_stall got halted=%b pc=%0d exp halted=1 pc=60", halted, pc_q); end
`else
    checks++; if (halted !== 1'b0 || pc_q !== 64'd64)
      begin fails++; $display("FAIL nohalt got halted=%b pc=%0d exp halted=0 pc=64", halted, pc_q); end
`endif
    do_redirect(64'd0);
    checks++; if (halted !== 1'b0 || pc_q !== 64'd0 || ifid_valid !== 1'b0)
      begin fails++; $display("FAIL halt_clear got halted=%b pc=%0d v=%b exp 0 0 0", halted, pc_q, ifid_valid); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_0000 || ifid_pc !== 64'd0 || pc_q !== 64'd4)
      begin fails++; $display("FAIL halt_resume got v=%b %h ipc=%0d pc=%0d exp v=1 10000000 ipc=0 pc=4",
                              ifid_valid, ifid_instr, ifid_pc, pc_q); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    for (int k = 0; k < 16; k++) mem[k] = 32'h1000_0000 + 32'(k);
    mem[15] = RV_HALT_INSN;
    test_reset();
    test_normal();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_alias_wrap();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the RISC-V pipeline. Holds the program counter and drives the instruction-memory address.
- Captures the combinationally returned instruction word into the IF/ID pipeline register.
- Honours stall (hold) and redirect (taken-branch flush) requests from downstream stages.
- Sits directly upstream of decode and directly drives the instruction port of the shared memory block.

Parameters:
- PC_W, 64, program-counter width in bits.
- IMEM_AW, 6, instruction-memory address width. Memory is indexed by byte PC, with instructions at multiples of 4.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- stall  input  1  hold PC and IF/ID contents this cycle.
- redirect  input  1  taken branch resolved downstream; load redirect_pc and flush IF/ID.
- redirect_pc  input  PC_W  branch target (byte address).
- i_mem_addr  output  IMEM_AW  equals pc[IMEM_AW-1:0], combinational from the PC register.
- i_mem_data  input  32  instruction word, valid in the same cycle as i_mem_addr.
- pc_q  output  PC_W  current fetch PC.
- ifid_valid  output  1  IF/ID holds a real instruction.
- ifid_instr  output  32  IF/ID instruction.
- ifid_pc  output  PC_W  PC of ifid_instr.
- halted  output  1  fetch halted (see Optional Feature); constant 0 when the feature is compiled out.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. rst_n is sampled on the rising edge of clk only.
- Reset values:
  - pc_q = RESET_PC.
  - ifid_valid = 0.
  - ifid_instr = 32'h0000_0013 (NOP, addi x0,x0,0).
  - ifid_pc = 0.
  - halted = 0.
- Latency: the word at pc_q is presented on i_mem_data in the same cycle and appears in IF/ID on the next edge. The first valid IF/ID entry appears one edge after rst_n rises.
- Per-edge priority (highest first): reset > redirect > halted > stall > normal.
  - Normal: pc_q <= pc_q + 4 (modulo 2^PC_W, wraps silently); ifid_instr <= i_mem_data; ifid_pc <= pc_q; ifid_valid <= 1.
  - Stall: pc_q and all IF/ID outputs hold their values.
  - Redirect (overrides stall):
    - pc_q <= {redirect_pc[PC_W-1:2], 2'b00}; target bits [1:0] are forced to 0.
    - ifid_valid <= 0 and ifid_instr <= NOP.
    - The instruction fetched that cycle is discarded (one-bubble penalty).
  - Redirect to the current pc_q: still flushes and refetches, giving one bubble.
- Address truncation: i_mem_addr is the low IMEM_AW bits of pc_q. Addresses alias modulo 2^IMEM_AW; no error is flagged.
- Reset asserted mid-stall or mid-redirect: reset wins and all state returns to reset values on that edge.

Optional Feature:
- Macro: IF_HALT_DETECT_EN.
- Enabled:
  - A 1-bit state register HALT tracks whether fetch is halted; it is cleared on reset.
  - Entering HALT: on a normal (non-stall, non-redirect) capture of i_mem_data == 32'h0000_0063 (BEQ x0,x0,0, self-loop), the word is written to IF/ID normally, then HALT <= 1.
  - While HALT: pc_q holds; ifid_valid <= 0 and ifid_instr <= NOP each edge unless stalled, in which case IF/ID holds; halted = 1.
  - redirect clears HALT and proceeds as a normal redirect, since the halt word may have been on a wrong path.
  - Stall while HALT: HALT is kept.
- Disabled: no halt detection; the self-loop word is fetched repeatedly; halted is tied to 0.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - RV_NOP = 32'h0000_0013 and RV_HALT_INSN = 32'h0000_0063.
  - Opcode constants (OP_BRANCH=7'b1100011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_RTYPE=7'b0110011).
  - PC_INC = 4.
- One natural sub-module: if_id_reg. It is the IF/ID register with hold and flush inputs and holds valid, instr and pc. The PC logic and halt FSM stay in the top module.

Test Plan:
- Reset then release, with memory words at 0/4/8 = A/B/C: IF/ID shows (A,pc 0), (B,4), (C,8) on edges 1-3. i_mem_addr sequence is 0,4,8,12.
- Stall high for 2 cycles at pc_q=8: pc_q stays 8 and IF/ID holds (B,4) for both cycles. After release, (C,8) is captured.
- Redirect with redirect_pc=16 while pc_q=20:
  - Next edge: ifid_valid=0, ifid_instr=NOP, pc_q=16.
  - Following edge: IF/ID = (mem[16],16).
- Redirect and stall in the same cycle, with redirect_pc=0x2E: redirect wins, pc_q=0x2C, and IF/ID is flushed.
- PC_W=8, pc_q=252 (IMEM_AW=6): next pc_q=0 and i_mem_addr=0 (wrap). Separately, pc_q=64 gives i_mem_addr=0 (alias).
- With IF_HALT_DETECT_EN and 0x00000063 at address 60:
  - After the capture, halted=1, pc_q stays 60, and ifid_valid=0 on later edges.
  - A redirect to 0 then clears halted, and fetch resumes at 0.
